alu_cmd_queue: RTL

//   Upstream stage of the combinational alu (op = f(a,b,sel)). Buffers {a,b,sel} commands in a

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_cmd_queue_if.sv | 39 +++
 rtl/alu_cmd_fifo.sv | 54 +++++
 rtl/alu_cmd_queue.sv | 109 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_cmd_queue shared types: default widths, FSM states, command bundle.
// Imported by the interface, the FIFO and the top level.
package alu_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_D_W   = 4;
  localparam int DEF_SEL_W = 4;
  localparam int DEF_OP_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_D_W-1:0]   a;
    logic [DEF_D_W-1:0]   b;
    logic [DEF_SEL_W-1:0] sel;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_queue_if.sv
// Command, alu and result buses of alu_cmd_queue.
// master = producer/alu/consumer side, slave = the queue.
interface alu_cmd_queue_if
  import alu_pkg::*;
#(
  parameter int D_W   = DEF_D_W,
  parameter int SEL_W = DEF_SEL_W,
  parameter int OP_W  = DEF_OP_W
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [D_W-1:0]   cmd_a;
  logic [D_W-1:0]   cmd_b;
  logic [SEL_W-1:0] cmd_sel;
  logic [D_W-1:0]   alu_a;
  logic [D_W-1:0]   alu_b;
  logic [SEL_W-1:0] alu_sel;
  logic [OP_W-1:0]  alu_op;
  logic             res_valid;
  logic             res_ready;
  logic [OP_W-1:0]  res_data;
  logic [SEL_W-1:0] res_sel;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel,
    output alu_op, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel,
    input  res_valid, res_data, res_sel
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel,
    input  alu_op, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel,
    output res_valid, res_data, res_sel
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; push gated by full, pop gated by empty.
// No read bypass: a push is visible at dout one cycle later.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  // storage write, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // pointers wrap modulo DEPTH, count tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// Queue + issue/hold FSM wrapping a combinational alu.
// ALU_DONE_CNT_EN enables the completed-result counter.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int D_W   = DEF_D_W,
  parameter int SEL_W = DEF_SEL_W,
  parameter int OP_W  = DEF_OP_W,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  alu_cmd_queue_if.slave bus,
  output logic [CW-1:0]  count,
  output logic [15:0]    done_cnt
);

  state_t state;
  cmd_t   in_cmd;
  cmd_t   head;
  logic   full;
  logic   empty;
  logic   pop;

  assign in_cmd = {bus.cmd_a, bus.cmd_b, bus.cmd_sel};
  assign bus.cmd_ready = !full;

  assign pop = !empty &&
               ((state == IDLE) ||
                ((state == HOLD) && bus.res_ready));

  alu_cmd_fifo #(
    .DEPTH(DEPTH),
    .W    ($bits(cmd_t))
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (bus.cmd_valid),
    .din  (in_cmd),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(count)
  );

  // issue head to the alu, capture its result, hold until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_sel   <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_sel   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            bus.alu_a   <= head.a;
            bus.alu_b   <= head.b;
            bus.alu_sel <= head.sel;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          bus.res_data  <= bus.alu_op;
          bus.res_sel   <= bus.alu_sel;
          bus.res_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            if (!empty) begin
              bus.alu_a   <= head.a;
              bus.alu_b   <= head.b;
              bus.alu_sel <= head.sel;
              state       <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_DONE_CNT_EN
  logic [15:0] done_q;

  // count result handshakes, wrapping at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= '0;
    end else if (bus.res_valid && bus.res_ready) begin
      done_q <= done_q + 16'd1;
    end
  end

  assign done_cnt = done_q;
`else
  assign done_cnt = '0;
`endif

endmodule
